gray_tick_decoder: RTL
======================

GRAY_TICK_DECODER -- requirements
Module: gray_tick_decoder

Interface
REQ-001 Parameter WIDTH, default 8, gray/binary code width.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 gray_in  input  WIDTH  gray count from the upstream gray counter; changes at most once per two clocks.
REQ-005 match_val  input  WIDTH  binary compare value.
REQ-006 err_clr  input  1  synchronous clear of sticky error.
REQ-007 bin_out  output  WIDTH  registered binary equivalent of the sampled gray value.
REQ-008 bin_valid  output  1  high once bin_out holds a decoded sample.
REQ-009 step  output  1  one-cycle pulse when the decoded value advances by exactly +1.
REQ-010 wrap  output  1  one-cycle pulse on a 2^WIDTH-1 to 0 step.
REQ-011 match  output  1  one-cycle pulse on a step whose new value equals match_val.
REQ-012 err  output  1  sticky flag for an illegal code transition.

Function
REQ-013 Pipeline: gray_in is sampled into g_s; g_s is decoded and registered as bin_out; latency is 2 clocks from gray_in to bin_out.
REQ-014 Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1] XOR g[i].
REQ-015 FSM states: EMPTY (no sample), PRIME (first bin_out loaded, no previous value), RUN.
REQ-016 EMPTY->PRIME on the first clock after reset release; PRIME->RUN on the next clock; RUN persists until reset.
REQ-017 bin_valid is 0 in EMPTY and 1 in PRIME and RUN.
REQ-018 In RUN, the new value is compared with the previous bin_out: equal -> no pulse; +1 mod 2^WIDTH -> step; any other value -> err set, no step/wrap/match.
REQ-019 wrap asserts with step only when the previous value is all-ones and the new value is 0.
REQ-020 match asserts with step only; a static bin_out equal to match_val gives no repeated pulse.
REQ-021 No step, wrap, match or err is generated in EMPTY or PRIME.
REQ-022 err remains set until err_clr; if err_clr and a new illegal transition coincide, err stays 1.
REQ-023 After an illegal transition, the new value becomes the reference; counting resumes without reset.

Reset
REQ-024 While rst=1: g_s=0, bin_out=0, bin_valid=0, step=wrap=match=err=0, FSM=EMPTY.
REQ-025 Reset mid-operation discards all history; the first post-reset value never produces step or err.

Configuration
REQ-026 Macro GRAY_TICK_SYNC_EN, when defined, inserts a two-flop synchronizer ahead of g_s (latency 4 clocks; EMPTY->PRIME waits for the synchronizer to fill, 3 clocks after reset release); when undefined, latency is 2 clocks and there is no synchronizer.

Structure
REQ-027 Shared package ula_gray_pkg holds the default WIDTH constant and the FSM state encoding.
REQ-028 Combinational decode lives in sub-module gray_to_bin (parameter WIDTH), instantiated once.

Verification
REQ-029 Reset, then gray_in driven by the upstream counter from 0 -> bin_out follows 0,1,2,... each value held 2 clocks; step pulses every other clock; err stays 0.
REQ-030 Count through 8'h80 gray (bin 255) to 8'h00 -> wrap and step pulse together exactly once; bin_out=0.
REQ-031 match_val=8'd5, count from 0 -> exactly one match pulse, coincident with bin_out becoming 5.
REQ-032 Force gray_in from 8'h01 (bin 1) to 8'h06 (bin 4) -> err=1, no step; next legal step from 4 to 5 -> step pulses, err still 1; err_clr pulse -> err=0.
REQ-033 Assert rst while bin_out=37 -> all outputs 0 immediately; release with gray_in=bin 40 -> bin_valid rises, no step, no err on first value.
REQ-034 Build with GRAY_TICK_SYNC_EN -> repeat REQ-029; first bin_out valid 2 clocks later than without the macro, pulse pattern otherwise identical.

Source files
------------

// File: rtl/ula_gray_pkg.sv
// Shared constants for the gray tick decoder: default code width and FSM state encoding.
package ula_gray_pkg;

    localparam int unsigned GRAY_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decode: each binary bit is the XOR of all gray bits at or above it.
module gray_to_bin
    import ula_gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // XOR-ing successively shifted copies gives the prefix-XOR from the MSB down.
    always_comb begin
        bin = gray;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            bin = bin ^ (gray >> k);
        end
    end

endmodule

// File: rtl/gray_tick_decoder.sv
// Samples an upstream gray count, registers its binary value and flags +1 steps, wraps, matches and illegal jumps.
// Optional macro GRAY_TICK_SYNC_EN adds a two-flop synchronizer ahead of the sample register.
module gray_tick_decoder
    import ula_gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic [WIDTH-1:0] match_val,
    input  logic             err_clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step,
    output logic             wrap,
    output logic             match,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] g_s_q, g_s_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] dec, bin_inc;
    logic [WIDTH-1:0] g_src;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             fill_done;

`ifdef GRAY_TICK_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [1:0]       fill_q, fill_d;

    // g_s only holds a real sample once both synchronizer stages have been loaded.
    always_comb begin
        sync1_d = gray_in;
        sync2_d = sync1_q;
        fill_d  = fill_q;
        if (fill_q != 2'd2) fill_d = fill_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fill_q  <= fill_d;
        end
    end

    assign g_src     = sync2_q;
    assign fill_done = (fill_q == 2'd2);
`else
    assign g_src     = gray_in;
    assign fill_done = 1'b1;
`endif

    gray_to_bin #(.WIDTH(WIDTH)) u_dec (
        .gray (g_s_q),
        .bin  (dec)
    );

    assign bin_inc = bin_q + 1'b1;

    always_comb begin
        g_s_d   = g_src;
        state_d = state_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        match_d = 1'b0;
        err_d   = err_q;
        if (err_clr) err_d = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (fill_done) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                bin_d   = dec;
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                bin_d = dec;
                // An illegal jump still loads dec, so it becomes the new reference.
                if (dec == bin_inc) begin
                    step_d  = 1'b1;
                    wrap_d  = (bin_q == '1);
                    match_d = (dec == match_val);
                end else if (dec != bin_q) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            g_s_q   <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_s_q   <= g_s_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = valid_q;
    assign step      = step_q;
    assign wrap      = wrap_q;
    assign match     = match_q;
    assign err       = err_q;

endmodule
